uart_tx_burst_sequencer: RTL and testbench
==========================================

Name: uart_tx_burst_sequencer

Overview:
Sequences bursts of bytes into the UART transmitter on behalf of the push-button/switch front end.
- On a start request, latches the burst length, inter-byte gap and base data byte.
- Issues one tx_start pulse per byte, tracks the transmitter's tx_busy handshake and inserts the programmed gap between bytes.
- Reports progress and completion to the top level (LED, 7-segment count).
- Sits between the chip top's input conditioning and the UART TX datapath.

Parameters:
TICKS_PER_MS, 100000, system_clock cycles per millisecond for the gap timer (benches override to a small value, e.g. 10).
DATA_W, 8, width of a transmitted byte.

Ports:
system_clock  input  1  single design clock.
cpu_rst  input  1  synchronous, active-high reset.
start_push  input  1  start request, level; its rising edge requests a burst.
abort  input  1  synchronous abort of the current burst.
num_bytes_to_send  input  2  burst length select: 00=1, 01=10, 10=128, 11=256.
delay  input  2  inter-byte gap select: 00=0 ms, 01=50 ms, 10=100 ms, 11=200 ms.
data_to_send  input  DATA_W  base byte of the burst.
tx_busy  input  1  UART TX is serialising a frame.
tx_start  output  1  one-cycle request to UART TX to load tx_data.
tx_data  output  DATA_W  byte presented to UART TX, stable from tx_start until tx_busy falls.
busy  output  1  burst in progress.
done  output  1  one-cycle pulse when a burst completes normally.
led_toggle  output  1  inverts on every done pulse.
byte_count  output  9  bytes completed in the current or last burst (0..256).

Behaviour:
- Reset is synchronous on cpu_rst, applied at the system_clock edge. Reset values: tx_start=0, tx_data=0, busy=0, done=0, led_toggle=0, byte_count=0; FSM=IDLE; edge-detect register=0.
- Start edge:
  - start_prev is registered every cycle; a request is start_push & ~start_prev.
  - A request is accepted only in IDLE. Requests arriving in any other state are dropped, not queued.
  - A held-high start_push does not retrigger.
- On accept, in the same edge:
  - latch N (1/10/128/256), gap ticks G = ms*TICKS_PER_MS, and base = data_to_send;
  - clear byte_count;
  - set busy=1 (busy rises the cycle after the edge is seen);
  - go to SEND.
- Byte i (0-based) is sent as tx_data = base + i, modulo 2^DATA_W; it wraps (0xFF is followed by 0x00).
- FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE, GAP, DONE.
  - SEND: if tx_busy=0, assert tx_start for exactly one cycle and go to WAIT_ACK. Otherwise hold in SEND with tx_start=0.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: on tx_busy=0, byte_count += 1. Then:
    - if byte_count (after increment) = N, go to DONE;
    - else if G=0, go to SEND;
    - else load gap counter with G-1 and go to GAP.
  - GAP: decrement each cycle; go to SEND after the cycle in which the counter is 0. The gap is exactly G cycles from WAIT_DONE exit to SEND entry.
  - DONE: done=1 for one cycle, led_toggle inverts, busy=0 on the next cycle, go to IDLE.
- Abort:
  - In any state other than IDLE, abort=1 forces IDLE on the next edge with busy=0 and tx_start=0.
  - No done pulse and no led_toggle change; byte_count holds its value.
  - Abort has priority over every other transition.
- cpu_rst has priority over abort and start.
- Width rules:
  - byte_count is 9 bits so that 256 is representable.
  - The gap counter is $clog2(200*TICKS_PER_MS) bits.
  - Burst-length comparison uses 9-bit N.
- The minimum spacing between tx_start pulses when G=0 is set by the transmitter (one frame), plus 2 cycles.

Decomposition:
- Package uart_seq_pkg holds:
  - state enum seq_state_t;
  - function decode_num_bytes(2b) returning 9b;
  - function decode_delay_ms(2b) returning 8b;
  - localparam DELAY_MS_MAX=200.
- One natural sub-module: gap_timer. It takes a load value, load strobe and enable; it outputs expired. It is reused by later button-debounce work.

Test Plan:
- TICKS_PER_MS=10, UART model with a 100-cycle frame: num=00, delay=00, data=0xA5, rising edge on start_push -> exactly 1 tx_start with tx_data=0xA5, done pulse, byte_count=1, led_toggle=1.
- num=01, delay=00, data=0x51 -> 10 tx_start pulses carrying 0x51..0x5A in order, busy high throughout, single done pulse, byte_count=10.
- num=11, delay=00, data=0xF0 -> 256 bytes; byte 16 is 0x00 (wrap), final byte is 0xEF, byte_count=256.
- num=00→01, delay=01 -> exactly 500 cycles between tx_busy falling and the next tx_start rising (G=50*10).
- start_push held high through a burst, plus a second edge while busy -> no extra burst; tx_start count equals N.
- Abort asserted after the 3rd byte of a 10-byte burst -> IDLE next cycle, no done, byte_count=3, led_toggle unchanged. Then cpu_rst mid-burst -> all outputs return to reset values the next edge.

Source files
------------

// File: rtl/uart_tx_burst_sequencer_pkg.sv
// Shared types and decode helpers for the UART TX burst sequencer.
package uart_seq_pkg;

    localparam int DELAY_MS_MAX = 200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP,
        S_DONE
    } seq_state_t;

    function automatic logic [8:0] decode_num_bytes(input logic [1:0] sel);
        logic [8:0] n;
        unique case (sel)
            2'b00: n = 9'd1;
            2'b01: n = 9'd10;
            2'b10: n = 9'd128;
            default: n = 9'd256;
        endcase
        return n;
    endfunction

    function automatic logic [7:0] decode_delay_ms(input logic [1:0] sel);
        logic [7:0] ms;
        unique case (sel)
            2'b00: ms = 8'd0;
            2'b01: ms = 8'd50;
            2'b10: ms = 8'd100;
            default: ms = 8'd200;
        endcase
        return ms;
    endfunction

endpackage

// File: rtl/uart_tx_burst_sequencer_if.sv
// Byte handshake between the burst sequencer and the UART transmitter.
interface uart_tx_burst_sequencer_if #(
    parameter int DATA_W = 8
);
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy
    );
endinterface

// File: rtl/uart_tx_burst_sequencer_gap_timer.sv
// Loadable down-counter; expired while the count sits at zero.
module gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);
endmodule

// File: rtl/uart_tx_burst_sequencer.sv
// Drives bursts of incrementing bytes into the UART TX with a
// programmable inter-byte gap, reporting progress and completion.
module uart_tx_burst_sequencer
    import uart_seq_pkg::*;
#(
    parameter int TICKS_PER_MS = 100000,
    parameter int DATA_W       = 8
) (
    input  logic                      system_clock,
    input  logic                      cpu_rst,
    input  logic                      start_push,
    input  logic                      abort,
    input  logic [1:0]                num_bytes_to_send,
    input  logic [1:0]                delay,
    input  logic [DATA_W-1:0]         data_to_send,
    uart_tx_burst_sequencer_if.master tx,
    output logic                      busy,
    output logic                      done,
    output logic                      led_toggle,
    output logic [8:0]                byte_count
);
    localparam int GAP_W = $clog2(DELAY_MS_MAX * TICKS_PER_MS);

    seq_state_t        state_q, state_d;
    logic              start_prev_q;
    logic [8:0]        n_q, n_d;
    logic [GAP_W-1:0]  g_q, g_d;
    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              busy_q, busy_d;
    logic              led_q, led_d;
    logic [8:0]        byte_count_q, byte_count_d;

    logic              start_req;
    logic              tx_start;
    logic              done_c;
    logic              gap_load;
    logic              gap_en;
    logic              gap_expired;
    logic [8:0]        next_count;
    logic [GAP_W-1:0]  gap_ticks;

    assign start_req  = start_push & ~start_prev_q;
    assign next_count = byte_count_q + 9'd1;
    assign gap_ticks  = GAP_W'(32'(decode_delay_ms(delay)) * TICKS_PER_MS);

    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        g_d          = g_q;
        base_d       = base_q;
        tx_data_d    = tx_data_q;
        busy_d       = busy_q;
        led_d        = led_q;
        byte_count_d = byte_count_q;
        tx_start     = 1'b0;
        done_c       = 1'b0;
        gap_load     = 1'b0;
        gap_en       = 1'b0;

        // Abort wins over every transition and suppresses all strobes.
        if ((state_q != S_IDLE) && abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_req) begin
                        n_d          = decode_num_bytes(num_bytes_to_send);
                        g_d          = gap_ticks;
                        base_d       = data_to_send;
                        tx_data_d    = data_to_send;
                        byte_count_d = '0;
                        busy_d       = 1'b1;
                        state_d      = S_SEND;
                    end
                end
                S_SEND: begin
                    if (!tx.tx_busy) begin
                        tx_start = 1'b1;
                        state_d  = S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (tx.tx_busy) begin
                        state_d = S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx.tx_busy) begin
                        byte_count_d = next_count;
                        if (next_count == n_q) begin
                            state_d = S_DONE;
                        end else begin
                            tx_data_d = base_q + DATA_W'(next_count);
                            if (g_q == '0) begin
                                state_d = S_SEND;
                            end else begin
                                gap_load = 1'b1;
                                state_d  = S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    gap_en = 1'b1;
                    if (gap_expired) begin
                        state_d = S_SEND;
                    end
                end
                S_DONE: begin
                    done_c  = 1'b1;
                    led_d   = ~led_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge system_clock) begin
        if (cpu_rst) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            n_q          <= '0;
            g_q          <= '0;
            base_q       <= '0;
            tx_data_q    <= '0;
            busy_q       <= 1'b0;
            led_q        <= 1'b0;
            byte_count_q <= '0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_push;
            n_q          <= n_d;
            g_q          <= g_d;
            base_q       <= base_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
            led_q        <= led_d;
            byte_count_q <= byte_count_d;
        end
    end

    gap_timer #(
        .W(GAP_W)
    ) u_gap_timer (
        .clk      (system_clock),
        .rst      (cpu_rst),
        .load     (gap_load),
        .load_val (g_q - GAP_W'(1)),
        .en       (gap_en),
        .expired  (gap_expired)
    );

    assign tx.tx_start = tx_start;
    assign tx.tx_data  = tx_data_q;
    assign busy        = busy_q;
    assign done        = done_c;
    assign led_toggle  = led_q;
    assign byte_count  = byte_count_q;
endmodule

// File: tb/tb_uart_tx_burst_sequencer.sv
// Scoreboard bench for the UART TX burst sequencer with a UART frame model.
module tb_uart_tx_burst_sequencer;

    localparam int TICKS = 10;
    localparam int FRAME = 100;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       cpu_rst = 1'b1;
    logic       start_push = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] num_sel = 2'b00;
    logic [1:0] dly_sel = 2'b00;
    logic [7:0] data_in = 8'h00;
    logic       busy;
    logic       done;
    logic       led_toggle;
    logic [8:0] byte_count;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    int   exp_done_q[$];
    int   starts = 0;
    int   dones = 0;
    int   cyc = 0;
    int   fall_cyc = 0;
    logic prev_busy = 1'b0;
    logic exp_led = 1'b0;
    int   uart_cnt = 0;

    uart_tx_burst_sequencer_if #(.DATA_W(8)) txif ();

    uart_tx_burst_sequencer #(
        .TICKS_PER_MS(TICKS),
        .DATA_W(8)
    ) dut (
        .system_clock      (clk),
        .cpu_rst           (cpu_rst),
        .start_push        (start_push),
        .abort             (abort),
        .num_bytes_to_send (num_sel),
        .delay             (dly_sel),
        .data_to_send      (data_in),
        .tx                (txif.master),
        .busy              (busy),
        .done              (done),
        .led_toggle        (led_toggle),
        .byte_count        (byte_count)
    );

    always #5 clk = ~clk;

    // UART model: busy for FRAME cycles after each accepted tx_start
    always @(posedge clk) begin
        if (cpu_rst) begin
            uart_cnt <= 0;
        end else if (txif.tx_start && uart_cnt == 0) begin
            uart_cnt <= FRAME;
        end else if (uart_cnt != 0) begin
            uart_cnt <= uart_cnt - 1;
        end
    end
    assign txif.tx_busy = (uart_cnt != 0);

    task automatic check(input string name, input longint got,
                         input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, got, got, exp, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every tx_start and done pulse
    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (!txif.tx_busy && prev_busy) fall_cyc = cyc;
        prev_busy = txif.tx_busy;
        if (txif.tx_start) begin
            starts++;
            if (exp_q.size() == 0) begin
                check("unexpected_tx_start", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", txif.tx_data, e.data);
                check("busy_during_send", busy, 1);
                if (e.gap >= 0) check("gap_cycles", cyc - fall_cyc - 1, e.gap);
            end
        end
        if (done) begin
            dones++;
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("done_byte_count", byte_count, exp_done_q.pop_front());
                check("busy_at_done", busy, 1);
            end
        end
    end

    task automatic push_bytes(input logic [7:0] base, input int n,
                              input int gap);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = base + 8'(i);
            e.gap  = (i == 0) ? -1 : gap;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start_push = 1'b1;
        @(posedge clk); #1 start_push = 1'b0;
    endtask

    task automatic wait_done(input int prev, input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (dones != prev) break;
        end
        check("done_seen", dones, prev + 1);
        if (dones != prev) exp_led = ~exp_led;
        @(negedge clk);
    endtask

    task automatic run_burst(input logic [1:0] num, input logic [1:0] dly,
                             input logic [7:0] base, input int n,
                             input int gap);
        int prev;
        prev = dones;
        push_bytes(base, n, gap);
        exp_done_q.push_back(n);
        num_sel = num;
        dly_sel = dly;
        data_in = base;
        pulse_start();
        wait_done(prev, n * (FRAME + 5 + gap) + 50);
        check("busy_after_done", busy, 0);
        check("led_toggle", led_toggle, exp_led);
        check("byte_count_final", byte_count, n);
        check("bytes_outstanding", exp_q.size(), 0);
    endtask

    initial begin : stim
        int prev_s;
        int prev_d;
        repeat (3) @(posedge clk);
        #1 cpu_rst = 1'b0;
        @(negedge clk);
        check("rst_tx_start", txif.tx_start, 0);
        check("rst_tx_data", txif.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_led", led_toggle, 0);
        check("rst_byte_count", byte_count, 0);

        run_burst(2'b00, 2'b00, 8'hA5, 1, 0);
        run_burst(2'b01, 2'b00, 8'h51, 10, 0);
        run_burst(2'b11, 2'b00, 8'hF0, 256, 0);
        run_burst(2'b01, 2'b01, 8'h22, 10, 50 * TICKS);

        // held start and a second edge mid-burst must not retrigger
        prev_s = starts;
        prev_d = dones;
        push_bytes(8'h80, 10, 0);
        exp_done_q.push_back(10);
        num_sel = 2'b01;
        dly_sel = 2'b00;
        data_in = 8'h80;
        @(posedge clk); #1 start_push = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (starts >= prev_s + 4) break;
        end
        @(posedge clk); #1 start_push = 1'b0;
        @(posedge clk); #1 start_push = 1'b1;
        wait_done(prev_d, 10 * (FRAME + 5) + 50);
        repeat (300) @(negedge clk);
        check("held_start_count", starts - prev_s, 10);
        check("held_done_count", dones - prev_d, 1);
        check("held_led", led_toggle, exp_led);
        #1 start_push = 1'b0;
        repeat (3) @(negedge clk);

        // abort during the gap after the 3rd byte
        prev_d = dones;
        push_bytes(8'h30, 3, 50 * TICKS);
        num_sel = 2'b01;
        dly_sel = 2'b01;
        data_in = 8'h30;
        pulse_start();
        for (int k = 0; k < 3 * (FRAME + 5 + 50 * TICKS) + 100; k++) begin
            @(negedge clk);
            if (byte_count == 9'd3) break;
        end
        check("abort_pre_count", byte_count, 3);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_tx_start", txif.tx_start, 0);
        check("abort_byte_count", byte_count, 3);
        check("abort_led", led_toggle, exp_led);
        repeat (700) @(negedge clk);
        check("abort_no_done", dones, prev_d);
        check("abort_no_more_bytes", exp_q.size(), 0);
        check("abort_idle_byte_count", byte_count, 3);

        // reset in the middle of a burst
        prev_s = starts;
        push_bytes(8'h10, 2, 0);
        num_sel = 2'b01;
        dly_sel = 2'b00;
        data_in = 8'h10;
        pulse_start();
        for (int k = 0; k < 2 * (FRAME + 5) + 50; k++) begin
            @(negedge clk);
            if (starts >= prev_s + 2) break;
        end
        check("rst_mid_starts", starts - prev_s, 2);
        @(posedge clk); #1 cpu_rst = 1'b1;
        @(posedge clk); #1 cpu_rst = 1'b0;
        @(negedge clk);
        exp_led = 1'b0;
        check("mrst_tx_start", txif.tx_start, 0);
        check("mrst_tx_data", txif.tx_data, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_led", led_toggle, exp_led);
        check("mrst_byte_count", byte_count, 0);
        repeat (200) @(negedge clk);
        check("mrst_no_more_bytes", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks %0d failures",
                 n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
